// File: rtl/reg_ctx_stack.sv
// Register-context stack: saves/restores a full register set per cycle with an
// internal stack pointer, full/empty status, sticky error flags and atomic swap.
module reg_ctx_stack #(
  parameter int WIDTH = 8,
  parameter int NREG  = 9,
  parameter int DEPTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  err_clr,
  input  logic [NREG*WIDTH-1:0] regs_in,
  output logic [NREG*WIDTH-1:0] regs_out,
  output logic                  restore_valid,
  output logic [AW:0]           sp,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DW = NREG * WIDTH;
  localparam logic [AW:0] SP_MAX = (AW + 1)'(DEPTH);
  localparam logic [AW:0] SP_ONE = (AW + 1)'(1);

  logic [DW-1:0] mem [DEPTH];

  logic [AW:0]   sp_dec;
  logic [AW-1:0] top_addr;
  logic [AW-1:0] wr_addr;
  logic          do_push;
  logic          do_pop;
  logic          do_swap;
  logic          ovf_evt;
  logic          unf_evt;
  logic          wr_en;
  logic          rd_en;

  assign full  = (sp == SP_MAX);
  assign empty = (sp == '0);

  // push+pop on an empty stack degrades to a plain push
  always_comb begin
    sp_dec   = sp - SP_ONE;
    top_addr = sp_dec[AW-1:0];
    do_swap  = push & pop & ~empty;
    do_push  = push & (~pop | empty) & ~full;
    do_pop   = pop & ~push & ~empty;
    ovf_evt  = push & ~pop & full;
    unf_evt  = pop & ~push & empty;
    wr_en    = ~rst & (do_push | do_swap);
    rd_en    = do_pop | do_swap;
    wr_addr  = do_swap ? top_addr : sp[AW-1:0];
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= regs_in;
    end
  end

  // regs_out is the registered read port; a same-edge swap write is not yet visible
  always_ff @(posedge clk) begin
    if (rst) begin
      sp            <= '0;
      regs_out      <= '0;
      restore_valid <= 1'b0;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      restore_valid <= rd_en;
      if (rd_en) begin
        regs_out <= mem[top_addr];
      end
      if (do_push) begin
        sp <= sp + SP_ONE;
      end else if (do_pop) begin
        sp <= sp_dec;
      end
      if (ovf_evt) begin
        overflow <= 1'b1;
      end else if (err_clr) begin
        overflow <= 1'b0;
      end
      if (unf_evt) begin
        underflow <= 1'b1;
      end else if (err_clr) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reg_ctx_stack.sv
// Bench for reg_ctx_stack: default 9x8x32 instance and a 4x16x5 instance share
// control inputs; both are checked every cycle against an array-based model.
module tb_reg_ctx_stack;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, push, pop, err_clr;
  logic [71:0] din_a;
  logic [63:0] din_b;

  logic [71:0] out_a;
  logic        rv_a, full_a, empty_a, ovf_a, unf_a;
  logic [5:0]  sp_a;
  logic [63:0] out_b;
  logic        rv_b, full_b, empty_b, ovf_b, unf_b;
  logic [3:0]  sp_b;

  reg_ctx_stack dut_a (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .err_clr(err_clr),
    .regs_in(din_a), .regs_out(out_a), .restore_valid(rv_a), .sp(sp_a),
    .full(full_a), .empty(empty_a), .overflow(ovf_a), .underflow(unf_a)
  );

  reg_ctx_stack #(.WIDTH(16), .NREG(4), .DEPTH(5)) dut_b (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .err_clr(err_clr),
    .regs_in(din_b), .regs_out(out_b), .restore_valid(rv_b), .sp(sp_b),
    .full(full_b), .empty(empty_b), .overflow(ovf_b), .underflow(unf_b)
  );

  int total = 0;
  int bad   = 0;

  // reference model: per instance, an array of stored contexts plus a count
  logic [71:0] mem_m [2][32];
  int          cnt   [2];
  logic [71:0] e_out [2];
  logic        e_rv  [2];
  logic        e_ovf [2];
  logic        e_unf [2];

  typedef struct {
    logic        r, p, q, c;
    logic [71:0] din;
    logic [5:0]  sp;
    logic        rv, uf;
    logic [71:0] dout;
  } vec_t;

  vec_t vt [11];

  function automatic vec_t mk(input logic r, input logic p, input logic q, input logic c,
                              input logic [71:0] d, input logic [5:0] s, input logic rv,
                              input logic uf, input logic [71:0] o);
    vec_t v;
    v.r = r; v.p = p; v.q = q; v.c = c; v.din = d;
    v.sp = s; v.rv = rv; v.uf = uf; v.dout = o;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [71:0] d;
    int dep;
    for (int i = 0; i < 2; i++) begin
      d   = (i == 0) ? din_a : {8'h00, din_b};
      dep = (i == 0) ? 32 : 5;
      if (rst) begin
        cnt[i] = 0; e_out[i] = '0; e_rv[i] = 1'b0; e_ovf[i] = 1'b0; e_unf[i] = 1'b0;
      end else begin
        e_rv[i] = 1'b0;
        if (err_clr) begin
          e_ovf[i] = 1'b0; e_unf[i] = 1'b0;
        end
        if (push && pop && cnt[i] > 0) begin
          e_out[i] = mem_m[i][cnt[i]-1];
          mem_m[i][cnt[i]-1] = d;
          e_rv[i] = 1'b1;
        end else if (push) begin
          if (cnt[i] < dep) begin
            mem_m[i][cnt[i]] = d;
            cnt[i]++;
          end else begin
            e_ovf[i] = 1'b1;
          end
        end else if (pop) begin
          if (cnt[i] > 0) begin
            cnt[i]--;
            e_out[i] = mem_m[i][cnt[i]];
            e_rv[i] = 1'b1;
          end else begin
            e_unf[i] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    chk("a.regs_out", out_a, e_out[0]);
    chk("a.restore_valid", 72'(rv_a), 72'(e_rv[0]));
    chk("a.sp", 72'(sp_a), 72'(cnt[0]));
    chk("a.full", 72'(full_a), 72'(cnt[0] == 32));
    chk("a.empty", 72'(empty_a), 72'(cnt[0] == 0));
    chk("a.overflow", 72'(ovf_a), 72'(e_ovf[0]));
    chk("a.underflow", 72'(unf_a), 72'(e_unf[0]));
    chk("b.regs_out", {8'h00, out_b}, e_out[1]);
    chk("b.restore_valid", 72'(rv_b), 72'(e_rv[1]));
    chk("b.sp", 72'(sp_b), 72'(cnt[1]));
    chk("b.full", 72'(full_b), 72'(cnt[1] == 5));
    chk("b.empty", 72'(empty_b), 72'(cnt[1] == 0));
    chk("b.overflow", 72'(ovf_b), 72'(e_ovf[1]));
    chk("b.underflow", 72'(unf_b), 72'(e_unf[1]));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic drive(input logic r, input logic p, input logic q, input logic c,
                       input logic [71:0] da, input logic [63:0] db);
    rst = r; push = p; pop = q; err_clr = c; din_a = da; din_b = db;
  endtask

  localparam logic [71:0] P1 = 72'h09_08_07_06_05_04_03_02_01;
  localparam logic [71:0] P2 = 72'h99_88_77_66_55_44_33_22_11;

  initial begin
    for (int i = 0; i < 2; i++) begin
      cnt[i] = 0; e_out[i] = '0; e_rv[i] = 1'b0; e_ovf[i] = 1'b0; e_unf[i] = 1'b0;
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);

    // basic push/pop, underflow and err_clr interplay on instance a
    vt[0]  = mk(1, 0, 0, 0, '0, 6'd0, 0, 0, '0);
    vt[1]  = mk(0, 1, 0, 0, P1, 6'd1, 0, 0, '0);
    vt[2]  = mk(0, 0, 1, 0, '0, 6'd0, 1, 0, P1);
    vt[3]  = mk(0, 0, 0, 0, '0, 6'd0, 0, 0, P1);
    vt[4]  = mk(0, 0, 1, 0, '0, 6'd0, 0, 1, P1);
    vt[5]  = mk(0, 0, 0, 1, '0, 6'd0, 0, 0, P1);
    vt[6]  = mk(0, 0, 1, 1, '0, 6'd0, 0, 1, P1);
    vt[7]  = mk(0, 0, 0, 0, '0, 6'd0, 0, 1, P1);
    vt[8]  = mk(0, 0, 0, 1, '0, 6'd0, 0, 0, P1);
    vt[9]  = mk(0, 1, 1, 0, P2, 6'd1, 0, 0, P1);
    vt[10] = mk(0, 0, 1, 0, '0, 6'd0, 1, 0, P2);

    for (int k = 0; k < 11; k++) begin
      drive(vt[k].r, vt[k].p, vt[k].q, vt[k].c, vt[k].din, vt[k].din[63:0]);
      cycle();
      chk($sformatf("vec%0d.sp", k), 72'(sp_a), 72'(vt[k].sp));
      chk($sformatf("vec%0d.rv", k), 72'(rv_a), 72'(vt[k].rv));
      chk($sformatf("vec%0d.underflow", k), 72'(unf_a), 72'(vt[k].uf));
      chk($sformatf("vec%0d.empty", k), 72'(empty_a), 72'(vt[k].sp == 6'd0));
      chk($sformatf("vec%0d.regs_out", k), out_a, vt[k].dout);
    end

    // fill to capacity and beyond, then drain in LIFO order
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    cycle();
    for (int k = 0; k < 33; k++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, {$urandom(), $urandom(), k[7:0]},
            {$urandom(), 16'h0, 8'h00, k[7:0]});
      cycle();
      if (k == 3) chk("b.full_at_4", 72'(full_b), 72'(0));
      if (k == 4) begin
        chk("b.full_at_5", 72'(full_b), 72'(1));
        chk("b.sp_at_5", 72'(sp_b), 72'(5));
      end
      if (k == 30) chk("a.full_at_31", 72'(full_a), 72'(0));
    end
    chk("a.sp_sat", 72'(sp_a), 72'(32));
    chk("a.full_sat", 72'(full_a), 72'(1));
    chk("a.overflow_set", 72'(ovf_a), 72'(1));
    chk("b.overflow_set", 72'(ovf_b), 72'(1));
    for (int k = 0; k < 32; k++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
      cycle();
      chk($sformatf("lifo%0d", k), 72'(out_a[7:0]), 72'(31 - k));
      chk($sformatf("lifo%0d.rv", k), 72'(rv_a), 72'(1));
    end
    chk("a.empty_after_drain", 72'(empty_a), 72'(1));

    // swap: push A, push B, push+pop C -> B; pop -> C; pop -> A
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    cycle();
    drive(1'b0, 1'b1, 1'b0, 1'b0, {9{8'hA0}}, 64'hA003_A002_A001_A000);
    cycle();
    drive(1'b0, 1'b1, 1'b0, 1'b0, {9{8'hB0}}, 64'hB003_B002_B001_B000);
    cycle();
    drive(1'b0, 1'b1, 1'b1, 1'b0, {9{8'hC0}}, 64'hC003_C002_C001_C000);
    cycle();
    chk("swap.a.out", out_a, {9{8'hB0}});
    chk("swap.a.sp", 72'(sp_a), 72'(2));
    chk("swap.b.lane1", 72'(out_b[31:16]), 72'(16'hB001));
    chk("swap.b.sp", 72'(sp_b), 72'(2));
    drive(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
    cycle();
    chk("swap.pop1.a", out_a, {9{8'hC0}});
    chk("swap.pop1.b", 72'(out_b), 72'(64'hC003_C002_C001_C000));
    cycle();
    chk("swap.pop2.a", out_a, {9{8'hA0}});
    chk("swap.pop2.b.lane3", 72'(out_b[63:48]), 72'(16'hA003));

    // reset in the cycle after a pop wipes the pending restore
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    cycle();
    for (int k = 1; k <= 3; k++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, {9{k[7:0]}}, {4{8'h00, k[7:0]}});
      cycle();
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
    cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    cycle();
    chk("rst_after_pop.rv", 72'(rv_a), 72'(0));
    chk("rst_after_pop.out", out_a, 72'(0));
    chk("rst_after_pop.sp", 72'(sp_a), 72'(0));
    drive(1'b0, 1'b1, 1'b0, 1'b0, {9{8'h5A}}, 64'h5A5A_5A5A_5A5A_5A5A);
    cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
    cycle();
    chk("rst_after_pop.x", out_a, {9{8'h5A}});
    chk("rst_after_pop.x.rv", 72'(rv_a), 72'(1));

    // random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 50,
            $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 5,
            {$urandom(), $urandom(), $urandom()}, {$urandom(), $urandom()});
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
